// File: rtl/nios2_cpu_mult_pipe.sv
// nios2_cpu_mult_pipe
// Pipelined WIDTHxWIDTH integer multiplier for the Nios II execute/memory path.
// Stage 1 forms four unsigned HALFxHALF partial products. Stage 2 sums them
// into the full 2*WIDTH product, applies the signed correction to the high
// half and selects the half requested by the op mode.
//
// Optional feature macro: NIOS2_MULT_PIPE_OUT_REG_EN
//   defined   -> extra plain output register stage (latency 3)
//   undefined -> outputs come straight from stage 2 (latency 2)
//
// Ports:
//   clk       rising-edge clock
//   reset_n   asynchronous active-low reset, clears every register
//   E_src1    operand A
//   E_src2    operand B
//   E_valid   operand/mode/tag valid this cycle
//   E_mode    00 MUL (low half), 01 MULXUU, 10 MULXSU, 11 MULXSS (high half)
//   E_tag     destination tag, passed through unchanged
//   M_en      pipeline advance enable (0 = stall)
//   flush     kill all in-flight ops; wins over stall
//   M_result  selected product half
//   M_valid   M_result/M_tag valid
//   M_tag     tag of the result
module nios2_cpu_mult_pipe #(
  parameter int WIDTH = 32,
  parameter int TAG_W = 5
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] E_src1,
  input  logic [WIDTH-1:0] E_src2,
  input  logic             E_valid,
  input  logic [1:0]       E_mode,
  input  logic [TAG_W-1:0] E_tag,
  input  logic             M_en,
  input  logic             flush,
  output logic [WIDTH-1:0] M_result,
  output logic             M_valid,
  output logic [TAG_W-1:0] M_tag
);

  localparam int HALF = WIDTH / 2;

  localparam logic [1:0] MODE_MUL = 2'b00;
  localparam logic [1:0] MODE_SS  = 2'b11;

  // Operand halves zero-extended to WIDTH so each product is a full WIDTH-bit
  // unsigned multiply (a HALFxHALF product always fits in WIDTH bits).
  logic [WIDTH-1:0] w_a_lo, w_a_hi, w_b_lo, w_b_hi;

  assign w_a_lo = {{HALF{1'b0}}, E_src1[HALF-1:0]};
  assign w_a_hi = {{HALF{1'b0}}, E_src1[WIDTH-1:HALF]};
  assign w_b_lo = {{HALF{1'b0}}, E_src2[HALF-1:0]};
  assign w_b_hi = {{HALF{1'b0}}, E_src2[WIDTH-1:HALF]};

  // ---------------- stage 1 ----------------
  logic [WIDTH-1:0] r_s1_ll, r_s1_lh, r_s1_hl, r_s1_hh;
  logic [WIDTH-1:0] r_s1_a, r_s1_b;
  logic [1:0]       r_s1_mode;
  logic [TAG_W-1:0] r_s1_tag;
  logic             r_s1_valid;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_s1_ll    <= '0;
      r_s1_lh    <= '0;
      r_s1_hl    <= '0;
      r_s1_hh    <= '0;
      r_s1_a     <= '0;
      r_s1_b     <= '0;
      r_s1_mode  <= '0;
      r_s1_tag   <= '0;
      r_s1_valid <= 1'b0;
    end else begin
      if (flush) begin
        r_s1_valid <= 1'b0;
      end else if (M_en) begin
        r_s1_valid <= E_valid;
      end
      // Data loads on every advancing cycle, bubbles included; only the
      // valid bit decides whether the slot means anything.
      if (M_en) begin
        r_s1_ll   <= w_a_lo * w_b_lo;
        r_s1_lh   <= w_a_lo * w_b_hi;
        r_s1_hl   <= w_a_hi * w_b_lo;
        r_s1_hh   <= w_a_hi * w_b_hi;
        r_s1_a    <= E_src1;
        r_s1_b    <= E_src2;
        r_s1_mode <= E_mode;
        r_s1_tag  <= E_tag;
      end
    end
  end

  // ---------------- stage 2 ----------------
  logic [2*WIDTH-1:0] w_ll_ext, w_lh_sh, w_hl_sh, w_hh_sh, w_prod;
  logic [WIDTH-1:0]   w_corr_a, w_corr_b, w_hi, w_sel;

  assign w_ll_ext = {{WIDTH{1'b0}}, r_s1_ll};
  assign w_lh_sh  = {{HALF{1'b0}}, r_s1_lh, {HALF{1'b0}}};
  assign w_hl_sh  = {{HALF{1'b0}}, r_s1_hl, {HALF{1'b0}}};
  assign w_hh_sh  = {r_s1_hh, {WIDTH{1'b0}}};
  assign w_prod   = w_ll_ext + w_lh_sh + w_hl_sh + w_hh_sh;

  // Two's-complement correction of the unsigned product's high half:
  // a negative A contributes -B*2^WIDTH (MULXSU and MULXSS, mode[1]=1),
  // a negative B contributes -A*2^WIDTH (MULXSS only).
  assign w_corr_a = (r_s1_mode[1] && r_s1_a[WIDTH-1]) ? r_s1_b : '0;
  assign w_corr_b = ((r_s1_mode == MODE_SS) && r_s1_b[WIDTH-1]) ? r_s1_a : '0;
  assign w_hi     = w_prod[2*WIDTH-1:WIDTH] - w_corr_a - w_corr_b;
  assign w_sel    = (r_s1_mode == MODE_MUL) ? w_prod[WIDTH-1:0] : w_hi;

  logic [WIDTH-1:0] r_s2_result;
  logic [TAG_W-1:0] r_s2_tag;
  logic             r_s2_valid;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_s2_result <= '0;
      r_s2_tag    <= '0;
      r_s2_valid  <= 1'b0;
    end else begin
      if (flush) begin
        r_s2_valid <= 1'b0;
      end else if (M_en) begin
        r_s2_valid <= r_s1_valid;
      end
      if (M_en) begin
        r_s2_result <= w_sel;
        r_s2_tag    <= r_s1_tag;
      end
    end
  end

`ifdef NIOS2_MULT_PIPE_OUT_REG_EN
  // ---------------- stage 3 (output register) ----------------
  logic [WIDTH-1:0] r_s3_result;
  logic [TAG_W-1:0] r_s3_tag;
  logic             r_s3_valid;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_s3_result <= '0;
      r_s3_tag    <= '0;
      r_s3_valid  <= 1'b0;
    end else begin
      if (flush) begin
        r_s3_valid <= 1'b0;
      end else if (M_en) begin
        r_s3_valid <= r_s2_valid;
      end
      if (M_en) begin
        r_s3_result <= r_s2_result;
        r_s3_tag    <= r_s2_tag;
      end
    end
  end

  assign M_result = r_s3_result;
  assign M_valid  = r_s3_valid;
  assign M_tag    = r_s3_tag;
`else
  assign M_result = r_s2_result;
  assign M_valid  = r_s2_valid;
  assign M_tag    = r_s2_tag;
`endif

endmodule

// File: tb/tb_nios2_cpu_mult_pipe.sv
// Directed bench for nios2_cpu_mult_pipe (WIDTH=32, TAG_W=5). Each vector
// carries its hand-computed result; a small slot model tracks when results
// should emerge under stall and flush. Latency follows the output-register
// macro NIOS2_MULT_PIPE_OUT_REG_EN.
module tb_nios2_cpu_mult_pipe;

`ifdef NIOS2_MULT_PIPE_OUT_REG_EN
  localparam int LAT = 3;
`else
  localparam int LAT = 2;
`endif

  logic        clk = 1'b0;
  logic        reset_n;
  logic [31:0] E_src1, E_src2;
  logic        E_valid;
  logic [1:0]  E_mode;
  logic [4:0]  E_tag;
  logic        M_en, flush;
  logic [31:0] M_result;
  logic        M_valid;
  logic [4:0]  M_tag;

  nios2_cpu_mult_pipe #(.WIDTH(32), .TAG_W(5)) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .E_src1   (E_src1),
    .E_src2   (E_src2),
    .E_valid  (E_valid),
    .E_mode   (E_mode),
    .E_tag    (E_tag),
    .M_en     (M_en),
    .flush    (flush),
    .M_result (M_result),
    .M_valid  (M_valid),
    .M_tag    (M_tag)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // expected slot contents, index LAT-1 is the output
  logic        m_v [LAT];
  logic [31:0] m_r [LAT];
  logic [4:0]  m_t [LAT];

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < LAT; i++) begin
      m_v[i] = 1'b0;
      m_r[i] = '0;
      m_t[i] = '0;
    end
  endtask

  // Drives one cycle of inputs, clocks, then checks outputs 1ns after the edge.
  task automatic drive(input string name, input logic v, input logic [1:0] mode,
                       input logic [31:0] a, input logic [31:0] b, input logic [4:0] tag,
                       input logic [31:0] exp_r, input logic en, input logic fl);
    E_valid = v;
    E_mode  = mode;
    E_src1  = a;
    E_src2  = b;
    E_tag   = tag;
    M_en    = en;
    flush   = fl;
    @(posedge clk);
    if (fl) begin
      for (int i = 0; i < LAT; i++) m_v[i] = 1'b0;
    end else if (en) begin
      for (int i = LAT - 1; i > 0; i--) begin
        m_v[i] = m_v[i-1];
        m_r[i] = m_r[i-1];
        m_t[i] = m_t[i-1];
      end
      m_v[0] = v;
      m_r[0] = exp_r;
      m_t[0] = tag;
    end
    #1;
    check_eq({name, ".valid"}, 64'(M_valid), 64'(m_v[LAT-1]));
    if (m_v[LAT-1]) begin
      check_eq({name, ".result"}, 64'(M_result), 64'(m_r[LAT-1]));
      check_eq({name, ".tag"}, 64'(M_tag), 64'(m_t[LAT-1]));
    end
  endtask

  task automatic op(input string name, input logic [1:0] mode, input logic [31:0] a,
                    input logic [31:0] b, input logic [4:0] tag, input logic [31:0] exp_r);
    drive(name, 1'b1, mode, a, b, tag, exp_r, 1'b1, 1'b0);
  endtask

  task automatic idle(input string name, input int n);
    for (int i = 0; i < n; i++) drive(name, 1'b0, 2'b00, '0, '0, '0, '0, 1'b1, 1'b0);
  endtask

  function automatic logic [31:0] ref_mult(input logic [1:0] mode, input logic [31:0] a,
                                           input logic [31:0] b);
    logic [63:0] ea, eb, p;
    ea = mode[1] ? {{32{a[31]}}, a} : {32'h0, a};
    eb = (mode == 2'b11) ? {{32{b[31]}}, b} : {32'h0, b};
    p  = ea * eb;
    return (mode == 2'b00) ? p[31:0] : p[63:32];
  endfunction

  initial begin
    reset_n = 1'b0;
    E_src1 = '0; E_src2 = '0; E_valid = 1'b0; E_mode = '0; E_tag = '0;
    M_en = 1'b1; flush = 1'b0;
    model_clear();
    #12;
    check_eq("reset.result", 64'(M_result), 64'h0);
    check_eq("reset.valid", 64'(M_valid), 64'h0);
    check_eq("reset.tag", 64'(M_tag), 64'h0);
    reset_n = 1'b1;
    @(posedge clk);
    #1;

    // basic MUL
    op("mul_basic", 2'b00, 32'h0001_0002, 32'h0003_0004, 5'd7, 32'h000A_0008);
    idle("mul_basic", LAT);

    // back-to-back all-ones in the three MULX modes
    op("ones_uu", 2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd1, 32'hFFFF_FFFE);
    op("ones_ss", 2'b11, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd2, 32'h0000_0000);
    op("ones_su", 2'b10, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd3, 32'hFFFF_FFFF);
    op("ones_mul", 2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd4, 32'h0000_0001);

    // hand-computed signed/unsigned corners, streamed
    op("min_ss", 2'b11, 32'h8000_0000, 32'h8000_0000, 5'd5, 32'h4000_0000);
    op("min_su", 2'b10, 32'h8000_0000, 32'h8000_0000, 5'd6, 32'hC000_0000);
    op("neg2x3_ss", 2'b11, 32'hFFFF_FFFE, 32'h0000_0003, 5'd8, 32'hFFFF_FFFF);
    op("3xmax_su", 2'b10, 32'h0000_0003, 32'hFFFF_FFFF, 5'd9, 32'h0000_0002);
    op("3xneg1_ss", 2'b11, 32'h0000_0003, 32'hFFFF_FFFF, 5'd10, 32'hFFFF_FFFF);
    op("shift_uu", 2'b01, 32'h1234_5678, 32'h0000_0010, 5'd11, 32'h0000_0001);
    op("shift_mul", 2'b00, 32'h1234_5678, 32'h0000_0010, 5'd12, 32'h2345_6780);
    op("wrap_mul", 2'b00, 32'hFFFF_0000, 32'h0001_0000, 5'd13, 32'h0000_0000);
    idle("stream_drain", LAT);

    // stall: X, Y issued, then a different op offered while stalled must be ignored
    op("stall_x", 2'b00, 32'h0000_0011, 32'h0000_0002, 5'd14, 32'h0000_0022);
    op("stall_y", 2'b01, 32'h8000_0000, 32'h0000_0004, 5'd15, 32'h0000_0002);
    for (int i = 0; i < 3; i++)
      drive("stall_hold", 1'b1, 2'b00, 32'd5, 32'd5, 5'd20, 32'd25, 1'b0, 1'b0);
    idle("stall_release", LAT + 1);

    // flush while stalled, with ops in flight
    op("flush_a", 2'b00, 32'd9, 32'd9, 5'd16, 32'd81);
    op("flush_b", 2'b00, 32'd8, 32'd8, 5'd17, 32'd64);
    drive("flush_stalled", 1'b0, 2'b00, '0, '0, '0, '0, 1'b0, 1'b1);
    drive("flush_after", 1'b0, 2'b00, '0, '0, '0, '0, 1'b0, 1'b0);
    idle("flush_after", LAT + 1);
    // flush in the same cycle as a new op drops it
    drive("flush_same", 1'b1, 2'b00, 32'd3, 32'd3, 5'd18, 32'd9, 1'b1, 1'b1);
    idle("flush_same", LAT);
    op("flush_recover", 2'b01, 32'hFFFF_FFFF, 32'h0000_0002, 5'd19, 32'h0000_0001);
    idle("flush_recover", LAT);

    // asynchronous reset mid-cycle with ops in flight
    op("rst_a", 2'b00, 32'd100, 32'd3, 5'd21, 32'd300);
    op("rst_b", 2'b00, 32'd200, 32'd3, 5'd22, 32'd600);
    #3;
    reset_n = 1'b0;
    #1;
    check_eq("async_rst.result", 64'(M_result), 64'h0);
    check_eq("async_rst.valid", 64'(M_valid), 64'h0);
    check_eq("async_rst.tag", 64'(M_tag), 64'h0);
    model_clear();
    E_valid = 1'b0;
    M_en = 1'b1;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk);
    #1;
    check_eq("post_rst.valid", 64'(M_valid), 64'h0);
    op("post_rst_mul", 2'b00, 32'd7, 32'd6, 5'd23, 32'h0000_002A);
    idle("post_rst", LAT);

    // mixed sweep with occasional stalls, checked against an independent 64-bit model
    for (int i = 0; i < 24; i++) begin
      logic [31:0] a, b;
      logic [1:0]  m;
      logic        en;
      a  = $urandom;
      b  = $urandom;
      m  = 2'($urandom_range(0, 3));
      en = ($urandom_range(0, 4) != 0);
      drive("sweep", 1'b1, m, a, b, 5'(i), ref_mult(m, a, b), en, 1'b0);
    end
    idle("sweep_drain", LAT + 1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not complete, expected finish before 100000 ns");
    $fatal(1);
  end

endmodule

// File: doc/nios2_cpu_mult_pipe.md
Name: nios2_cpu_mult_pipe

Overview:
- Parametrised, pipelined integer multiplier for the Nios II execute/memory path; generalises the fixed 32-bit three-partial-product cell.
- Produces the full 2*WIDTH product and returns low or high half per op mode (MUL, MULXUU, MULXSU, MULXSS).
- Carries a valid bit and destination tag alongside the data; honours pipeline stall and flush from the CPU control logic.

Parameters:
- WIDTH, 32, operand width; even, 8..64; HALF = WIDTH/2 is derived.
- TAG_W, 5, width of the pass-through destination register tag.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- reset_n  in  1  asynchronous active-low reset.
- E_src1  in  WIDTH  operand A.
- E_src2  in  WIDTH  operand B.
- E_valid  in  1  operand/mode/tag valid this cycle.
- E_mode  in  2  00 MUL (low half), 01 MULXUU, 10 MULXSU (A signed, B unsigned), 11 MULXSS; the three MULX modes return the high half.
- E_tag  in  TAG_W  destination tag, passed through unchanged.
- M_en  in  1  pipeline advance enable; 0 = stall.
- flush  in  1  kill all in-flight operations.
- M_result  out  WIDTH  selected product half.
- M_valid  out  1  M_result/M_tag valid.
- M_tag  out  TAG_W  tag of the result.

Behaviour:
- Stage 1, registered when M_en=1: four unsigned HALFxHALF partial products: ll=A[lo]*B[lo], lh=A[lo]*B[hi], hl=A[hi]*B[lo], hh=A[hi]*B[hi]. Each is WIDTH bits. Mode, tag and valid are registered alongside.
- Stage 2, registered when M_en=1:
  - P = ll + (lh<<HALF) + (hl<<HALF) + (hh<<WIDTH), computed modulo 2^(2*WIDTH).
  - Signed correction on the high half, modulo 2^WIDTH:
    - MULXSS: subtract B when A[msb]=1, and subtract A when B[msb]=1.
    - MULXSU: subtract B when A[msb]=1 only.
    - MULXUU and MUL: no correction.
  - The selected half is registered into M_result.
- Latency: 2 advancing cycles from E_valid to M_valid. Throughput: 1 op/cycle.
- Stall: when M_en=0, every pipeline register (data, mode, tag, valid) holds its value. M_result, M_valid and M_tag stay stable. New inputs are ignored.
- Flush: synchronous; all valid bits clear on the next edge regardless of M_en. Data registers may keep stale contents.
  - flush and E_valid in the same cycle: the op is dropped.
  - flush has priority over stall.
- Bubbles: when E_valid=0 the stage-1 valid is cleared and data registers still load (don't-care). M_valid=0 for that slot.
- Reset (reset_n low, any time including mid-operation): every register clears to 0 immediately. M_result=0, M_valid=0, M_tag=0. No op in flight survives. The first valid op after deassertion appears after the full latency.
- Overflow is not flagged; the MUL low half wraps modulo 2^WIDTH.

Optional Feature:
- Macro: NIOS2_MULT_PIPE_OUT_REG_EN.
- Defined: adds stage 3, a plain output register on M_result/M_valid/M_tag with the same stall, flush and reset rules. Latency becomes 3.
- Undefined: latency is 2 and outputs come directly from stage 2.

Test Plan (WIDTH=32, TAG_W=5, macro undefined unless stated):
- MUL 0x00010002 x 0x00030004, tag 7, M_en=1 -> after 2 cycles M_result=0x000A0008, M_valid=1, M_tag=7.
- 0xFFFFFFFF x 0xFFFFFFFF on consecutive cycles in MULXUU, MULXSS, MULXSU -> M_result 0xFFFFFFFE, 0x00000000, 0xFFFFFFFF on three consecutive cycles.
- Issue two ops back-to-back, drop M_en for 3 cycles after the first edge -> outputs frozen for 3 cycles. Both results then emerge in order with correct tags, with no duplicates or losses.
- Ops in stages 1 and 2, assert flush for one cycle while M_en=0 -> M_valid=0 next cycle and stays 0 until a new E_valid op completes.
- Pull reset_n low asynchronously mid-cycle with two ops in flight -> M_result=0, M_valid=0 before the next edge. After release, MUL 0x7 x 0x6 gives 0x2A two cycles later.
- With NIOS2_MULT_PIPE_OUT_REG_EN defined, rerun the first scenario -> 0x000A0008 after 3 cycles. Random signed/unsigned sweep, including 0x80000000 x 0x80000000 MULXSS -> 0x40000000, matches the reference model.
